divider: RTL and testbench
==========================

# divider

Iterative 32-bit integer divider for the execute stage, the multi-cycle counterpart to the combinational multiplier. It accepts a dividend/divisor pair with a start pulse and runs a radix-2 restoring division, one quotient bit per cycle. It returns remainder and quotient packed as {HI, LO} in the same 64-bit result format the multiplier uses. The HI/LO writeback logic can therefore take either unit's result without reformatting.

## Interface
- WIDTH, 32, operand width; quotient and remainder are each WIDTH bits, Out is 2*WIDTH.
- Clock  input  1  system clock, all state updates on the rising edge.
- Reset  input  1  synchronous, active-high reset.
- Start  input  1  request a division; sampled only in IDLE.
- Signed  input  1  1 = two's-complement division, 0 = unsigned; captured with Start.
- Flush  input  1  pipeline flush; aborts any in-flight division.
- A  input  WIDTH  dividend, captured on the accepted Start edge.
- B  input  WIDTH  divisor, captured on the accepted Start edge.
- Busy  output  1  high whenever the state is not IDLE.
- Done  output  1  single-cycle pulse when Out holds a new result.
- Out  output  2*WIDTH  {remainder, quotient}, registered.

## Operation
- States:
  - IDLE: Start=1 and Flush=0 captures |A|, |B|, sign flags and Signed; clears the 6-bit counter, partial remainder and quotient; moves to CALC.
  - CALC: one restoring step per cycle.
    - Shift {rem, quo} left by 1.
    - trial = rem - divisor (WIDTH+1 bits).
    - If trial is non-negative, rem = trial and quo[0] = 1; otherwise quo[0] = 0.
    - After step WIDTH-1, move to DONE and register the corrected result into Out.
  - DONE: Done=1 for this cycle only; unconditionally return to IDLE.
- Magnitudes: |X| is used only when Signed=1 and X[WIDTH-1]=1; otherwise X is used unchanged. Width is WIDTH bits, so |0x80000000| = 0x80000000 unsigned.
- Sign correction (Signed=1 only):
  - Negate the quotient when sign(A) XOR sign(B).
  - Negate the remainder when sign(A); the remainder sign follows the dividend.
- Divide by zero: Out = {A, 32'hFFFFFFFF} for both Signed values. Latency is unchanged.
- Signed overflow: 0x80000000 / 0xFFFFFFFF gives quotient 0x80000000 and remainder 0. This falls out of the magnitude path and needs no special case.
- Start while Busy: ignored. It is neither queued nor able to change the captured operands.
- Flush: from any state, go to IDLE on the next edge.
  - No Done pulse is produced; a Flush in the DONE cycle does not cancel that cycle's Done.
  - Out is not modified.
  - Flush and Start in the same IDLE cycle: Flush wins and nothing starts.
- Reset: from any state, including mid-CALC, go to IDLE. Out = 0, Done = 0, Busy = 0, counter = 0.
- Out holds its value from DONE until the next result is written. Neither Flush nor Start clears it.

## Timing
- Cycle 0: Start sampled high in IDLE.
- Cycles 1 to 32: CALC, Busy=1.
- Cycle 33: DONE, Done=1, Out valid.
- Cycle 34: IDLE, Busy=0.
- Latency is a fixed 33 cycles from Start to Done. Zero divisor and small operands do not shorten it.
- A new Start is accepted in cycle 34 at the earliest. Back-to-back issue interval is 34 cycles.
- Busy is a registered decode of the state, with no combinational path from Start. Done is likewise registered.
- Reset values: Busy=0, Done=0, Out=64'h0.

## Structure
- div_pkg holds:
  - div_state_t enum {IDLE, CALC, DONE};
  - localparam DIV_ITER = 32;
  - the counter width, $clog2(DIV_ITER)+1.
- Sub-module div_step: combinational, one restoring iteration. Inputs are rem, quo and divisor; outputs are the next rem and next quo. Instantiated once and reused each cycle.
- The top level holds the FSM, counter, operand registers and sign-correction logic.

## Test plan
- Unsigned 100 / 7, Signed=0: Done exactly in cycle 33 and Out = {32'd2, 32'd14}. Busy is high in cycles 1 to 33 only.
- Signed -7 / 2 (A=0xFFFFFFF9, B=2): Out = {32'hFFFFFFFF, 32'hFFFFFFFD}. Then 7 / -2 gives Out = {32'd1, 32'hFFFFFFFD}.
- B=0 with A=0x12345678, for Signed=0 and Signed=1: Out = {32'h12345678, 32'hFFFFFFFF}, Done in cycle 33. Then signed 0x80000000 / 0xFFFFFFFF gives Out = {32'h0, 32'h80000000}.
- Start pulsed again in cycle 10 with different operands: ignored, and the original result is unchanged.
- Flush or Start interactions:
  - Flush in cycle 15: Busy falls in cycle 16 and no Done pulse occurs.
  - A following Start then completes normally.
  - Flush and Start together in IDLE: nothing starts.
- Reset asserted in cycle 20: the next cycle shows Busy=0, Done=0, Out=0. A fresh 100 / 7 then completes in 33 cycles.

Source files
------------

// File: rtl/div_pkg.sv
// Shared types and sizing for the iterative divider.
package div_pkg;

   typedef enum logic [1:0] {IDLE, CALC, DONE} div_state_t;

   localparam int unsigned DIV_ITER  = 32;
   localparam int unsigned DIV_CNT_W = $clog2(DIV_ITER) + 1;

endpackage

// File: rtl/div_step.sv
// One radix-2 restoring division iteration, purely combinational.
module div_step #(
   parameter int unsigned WIDTH = 32
) (
   input  logic [WIDTH-1:0] rem,
   input  logic [WIDTH-1:0] quo,
   input  logic [WIDTH-1:0] divisor,
   output logic [WIDTH-1:0] rem_next,
   output logic [WIDTH-1:0] quo_next
);

   logic [WIDTH:0] shifted;
   logic [WIDTH:0] trial;

   // rem < divisor on entry, so the WIDTH+1-bit trial never wraps past its sign bit
   always_comb begin
      shifted  = {rem, quo[WIDTH-1]};
      trial    = shifted - {1'b0, divisor};
      quo_next = {quo[WIDTH-2:0], ~trial[WIDTH]};
      rem_next = trial[WIDTH] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
   end

endmodule

// File: rtl/divider.sv
// Multi-cycle signed/unsigned divider; result packed as {remainder, quotient}.
module divider
   import div_pkg::*;
#(
   parameter int unsigned WIDTH = 32
) (
   input  logic               Clock,
   input  logic               Reset,
   input  logic               Start,
   input  logic               Signed,
   input  logic               Flush,
   input  logic [WIDTH-1:0]   A,
   input  logic [WIDTH-1:0]   B,
   output logic               Busy,
   output logic               Done,
   output logic [2*WIDTH-1:0] Out
);

   div_state_t             state;
   logic [DIV_CNT_W-1:0]   cnt;
   logic [WIDTH-1:0]       rem;
   logic [WIDTH-1:0]       quo;
   logic [WIDTH-1:0]       dvs;
   logic [WIDTH-1:0]       a_raw;
   logic                   neg_q;
   logic                   neg_r;
   logic                   dvs_zero;

   logic [WIDTH-1:0]       a_mag;
   logic [WIDTH-1:0]       b_mag;
   logic [WIDTH-1:0]       rem_nx;
   logic [WIDTH-1:0]       quo_nx;
   logic [WIDTH-1:0]       q_fix;
   logic [WIDTH-1:0]       r_fix;
   logic [2*WIDTH-1:0]     result;

   div_step #(.WIDTH(WIDTH)) u_step (
      .rem      (rem),
      .quo      (quo),
      .divisor  (dvs),
      .rem_next (rem_nx),
      .quo_next (quo_nx)
   );

   always_comb begin
      a_mag  = (Signed && A[WIDTH-1]) ? -A : A;
      b_mag  = (Signed && B[WIDTH-1]) ? -B : B;
      q_fix  = neg_q ? -quo_nx : quo_nx;
      r_fix  = neg_r ? -rem_nx : rem_nx;
      result = dvs_zero ? {a_raw, {WIDTH{1'b1}}} : {r_fix, q_fix};
   end

   always_ff @(posedge Clock) begin
      if (Reset) begin
         state    <= IDLE;
         cnt      <= '0;
         rem      <= '0;
         quo      <= '0;
         dvs      <= '0;
         a_raw    <= '0;
         neg_q    <= 1'b0;
         neg_r    <= 1'b0;
         dvs_zero <= 1'b0;
         Out      <= '0;
         Busy     <= 1'b0;
         Done     <= 1'b0;
      end else if (Flush) begin
         state <= IDLE;
         Busy  <= 1'b0;
         Done  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               Done <= 1'b0;
               if (Start) begin
                  // dividend is loaded into quo and shifted into rem one bit per step
                  cnt      <= '0;
                  rem      <= '0;
                  quo      <= a_mag;
                  dvs      <= b_mag;
                  a_raw    <= A;
                  neg_q    <= Signed & (A[WIDTH-1] ^ B[WIDTH-1]);
                  neg_r    <= Signed & A[WIDTH-1];
                  dvs_zero <= (B == '0);
                  state    <= CALC;
                  Busy     <= 1'b1;
               end
            end
            CALC: begin
               rem <= rem_nx;
               quo <= quo_nx;
               cnt <= cnt + 1'b1;
               if (cnt == DIV_CNT_W'(WIDTH - 1)) begin
                  Out   <= result;
                  Done  <= 1'b1;
                  state <= DONE;
               end
            end
            DONE: begin
               Done  <= 1'b0;
               Busy  <= 1'b0;
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
               Busy  <= 1'b0;
               Done  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_divider.sv
// Self-checking bench for divider: directed corner cases plus random operands.
module tb_divider;

   logic        Clock = 1'b0;
   logic        Reset;
   logic        Start;
   logic        Signed;
   logic        Flush;
   logic [31:0] A;
   logic [31:0] B;
   logic        Busy;
   logic        Done;
   logic [63:0] Out;

   int          n_assert = 0;
   int          n_fail   = 0;
   logic [63:0] exp_out  = '0;

   divider #(.WIDTH(32)) dut (
      .Clock  (Clock),
      .Reset  (Reset),
      .Start  (Start),
      .Signed (Signed),
      .Flush  (Flush),
      .A      (A),
      .B      (B),
      .Busy   (Busy),
      .Done   (Done),
      .Out    (Out)
   );

   always #5 Clock = ~Clock;

   function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b, input logic s);
      longint la, lb, q, r;
      if (b == 32'd0) return {a, 32'hFFFFFFFF};
      if (s) begin
         la = longint'($signed(a));
         lb = longint'($signed(b));
         q  = la / lb;
         r  = la % lb;
         return {r[31:0], q[31:0]};
      end
      return {a % b, a / b};
   endfunction

   task automatic chk(input string tag, input int c, input logic [63:0] obs, input logic [63:0] expv);
      n_assert++;
      assert (obs === expv)
      else begin
         n_fail++;
         $error("FAIL %s c%0d: observed %h expected %h", tag, c, obs, expv);
      end
   endtask

   // kind: 0 plain, 1 second Start at cycle ev, 2 Flush at cycle ev, 3 Reset at cycle ev
   task automatic run(input logic [31:0] a, input logic [31:0] b, input logic s,
                      input int kind, input int ev, input string tag);
      logic [63:0] res;
      logic [63:0] out_e;
      logic        abort;
      int          end_busy;
      res      = model(a, b, s);
      abort    = (kind == 2) || (kind == 3);
      end_busy = abort ? ev : 33;
      @(negedge Clock);
      A = a; B = b; Signed = s; Start = 1'b1;
      for (int c = 1; c <= 34; c++) begin
         @(negedge Clock);
         Start = 1'b0; Flush = 1'b0; Reset = 1'b0;
         chk({tag, " busy"}, c, {63'd0, Busy}, {63'd0, c <= end_busy});
         chk({tag, " done"}, c, {63'd0, Done}, {63'd0, !abort && c == 33});
         if (kind == 3 && c > ev)      out_e = '0;
         else if (!abort && c >= 33)   out_e = res;
         else                          out_e = exp_out;
         chk({tag, " out"}, c, Out, out_e);
         if (c == ev) begin
            case (kind)
               1: begin
                  A = $urandom; B = $urandom_range(1, 255); Signed = ~s; Start = 1'b1;
               end
               2: Flush = 1'b1;
               3: Reset = 1'b1;
               default: ;
            endcase
         end
      end
      if (kind == 3)  exp_out = '0;
      else if (!abort) exp_out = res;
   endtask

   initial begin
      logic [31:0] ra, rb;
      logic        rs;
      Reset = 1'b1; Start = 1'b0; Signed = 1'b0; Flush = 1'b0; A = '0; B = '0;
      repeat (3) @(negedge Clock);
      chk("reset busy", 0, {63'd0, Busy}, 64'd0);
      chk("reset done", 0, {63'd0, Done}, 64'd0);
      chk("reset out",  0, Out, 64'd0);
      Reset = 1'b0;

      run(32'd100, 32'd7, 1'b0, 0, 0, "u100_7");
      run(32'hFFFFFFF9, 32'd2, 1'b1, 0, 0, "s-7_2");
      chk("s-7_2 const", 0, exp_out, {32'hFFFFFFFF, 32'hFFFFFFFD});
      run(32'd7, 32'hFFFFFFFE, 1'b1, 0, 0, "s7_-2");
      chk("s7_-2 const", 0, exp_out, {32'd1, 32'hFFFFFFFD});
      run(32'h12345678, 32'd0, 1'b0, 0, 0, "udiv0");
      run(32'h12345678, 32'd0, 1'b1, 0, 0, "sdiv0");
      chk("sdiv0 const", 0, exp_out, {32'h12345678, 32'hFFFFFFFF});
      run(32'h80000000, 32'hFFFFFFFF, 1'b1, 0, 0, "sovf");
      chk("sovf const", 0, exp_out, {32'h0, 32'h80000000});
      run(32'hDEADBEEF, 32'd1000, 1'b0, 1, 10, "restart");
      run(32'd5000, 32'd3, 1'b0, 2, 15, "flush");
      run(32'd123456, 32'd321, 1'b1, 0, 0, "postflush");

      @(negedge Clock);
      A = 32'd5; B = 32'd1; Signed = 1'b0; Start = 1'b1; Flush = 1'b1;
      for (int c = 1; c <= 4; c++) begin
         @(negedge Clock);
         Start = 1'b0; Flush = 1'b0;
         chk("flushstart busy", c, {63'd0, Busy}, 64'd0);
         chk("flushstart done", c, {63'd0, Done}, 64'd0);
         chk("flushstart out",  c, Out, exp_out);
      end

      run(32'd999, 32'd10, 1'b0, 3, 20, "reset20");
      run(32'd100, 32'd7, 1'b0, 0, 0, "fresh");

      for (int i = 0; i < 16; i++) begin
         ra = $urandom;
         if ($urandom_range(0, 7) == 0) ra = 32'h80000000;
         case ($urandom_range(0, 3))
            0:       rb = 32'd0;
            1:       rb = $urandom_range(1, 15);
            2:       rb = 32'hFFFFFFFF - $urandom_range(0, 15);
            default: rb = $urandom;
         endcase
         rs = 1'($urandom_range(0, 1));
         run(ra, rb, rs, 0, 0, $sformatf("rand%0d", i));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
